// File: rtl/poly_factor_recover_if.sv
// Request/result handshake bundle for poly_factor_recover.
// The master drives the request and consumes the result; the slave is the divider.
interface poly_factor_recover_if #(
  parameter int W = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] in_p;
  logic [W-1:0]   in_d;
  logic [1:0]     in_sel;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_q;
  logic [W-1:0]   out_r;
  logic           out_exact;
  logic           out_dz;
  logic           out_ovf;
  logic [1:0]     out_sel;

  modport master (
    output in_valid, in_p, in_d, in_sel, out_ready,
    input  in_ready, out_valid, out_q, out_r, out_exact, out_dz, out_ovf, out_sel
  );

  modport slave (
    input  in_valid, in_p, in_d, in_sel, out_ready,
    output in_ready, out_valid, out_q, out_r, out_exact, out_dz, out_ovf, out_sel
  );
endinterface

// File: rtl/poly_factor_recover.sv
// Recovers the unknown factor of a 2W-bit product by restoring division,
// one quotient bit per clock, with divide-by-zero and overflow short-cuts.
module poly_factor_recover #(
  parameter int W  = 16,
  parameter int CW = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  poly_factor_recover_if.slave  io_bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_lo;
  logic [W-1:0]   r_d;
  logic [1:0]     r_sel;
  logic [CW-1:0]  r_cnt;
  logic           r_in_ready;
  logic           r_out_valid;
  logic [W-1:0]   r_q;
  logic [W-1:0]   r_r;
  logic           r_exact;
  logic           r_dz;
  logic           r_ovf;
  logic [1:0]     r_out_sel;

  // r_lo holds the unconsumed dividend bits on top and collects quotient bits underneath.
  logic [W:0]     w_rem_ext;
  logic [W:0]     w_rem_sub;
  logic           w_ge;
  logic [W-1:0]   w_rem_next;
  logic [W-1:0]   w_q_next;
  logic [W-1:0]   w_hi;

  assign w_rem_ext  = {r_rem, r_lo[W-1]};
  assign w_ge       = (w_rem_ext >= {1'b0, r_d});
  assign w_rem_sub  = w_rem_ext - {1'b0, r_d};
  assign w_rem_next = w_ge ? w_rem_sub[W-1:0] : w_rem_ext[W-1:0];
  assign w_q_next   = {r_lo[W-2:0], w_ge};
  assign w_hi       = io_bus.in_p[2*W-1:W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_lo        <= '0;
      r_d         <= '0;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_q         <= '0;
      r_r         <= '0;
      r_exact     <= 1'b0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_sel   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.in_valid && r_in_ready) begin
            r_d        <= io_bus.in_d;
            r_sel      <= io_bus.in_sel;
            r_in_ready <= 1'b0;
            if (io_bus.in_sel == 2'd0) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_q         <= '0;
              r_r         <= io_bus.in_p[W-1:0];
              r_exact     <= (io_bus.in_p == '0);
              r_dz        <= 1'b0;
              r_ovf       <= 1'b0;
              r_out_sel   <= io_bus.in_sel;
            end else if (io_bus.in_d == '0) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_q         <= '1;
              r_r         <= '0;
              r_exact     <= 1'b0;
              r_dz        <= 1'b1;
              r_ovf       <= 1'b0;
              r_out_sel   <= io_bus.in_sel;
            end else if (w_hi >= io_bus.in_d) begin
              // Quotient would need more than W bits.
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_q         <= '1;
              r_r         <= '0;
              r_exact     <= 1'b0;
              r_dz        <= 1'b0;
              r_ovf       <= 1'b1;
              r_out_sel   <= io_bus.in_sel;
            end else begin
              r_state <= S_RUN;
              r_rem   <= w_hi;
              r_lo    <= io_bus.in_p[W-1:0];
              r_cnt   <= '0;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_next;
          r_lo  <= w_q_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W - 1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_q         <= w_q_next;
            r_r         <= w_rem_next;
            r_exact     <= (w_rem_next == '0);
            r_dz        <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_sel   <= r_sel;
          end
        end
        S_DONE: begin
          if (io_bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_q     = r_q;
  assign io_bus.out_r     = r_r;
  assign io_bus.out_exact = r_exact;
  assign io_bus.out_dz    = r_dz;
  assign io_bus.out_ovf   = r_ovf;
  assign io_bus.out_sel   = r_out_sel;
endmodule

// File: tb/tb_poly_factor_recover.sv
// Scoreboard bench for poly_factor_recover: expected results are queued at
// request time from an arithmetic model and compared when the DUT answers.
module tb_poly_factor_recover;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  poly_factor_recover_if #(.W(W)) bus ();

  poly_factor_recover #(.W(W), .CW(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  // Result packing: {q, r, exact, dz, ovf, sel}; edges = clock edges from accept to out_valid.
  typedef struct {
    logic [36:0] res;
    int          edges;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic exp_t model(input logic [31:0] p, input logic [15:0] d, input logic [1:0] sel);
    exp_t        e;
    logic [31:0] q32;
    logic [31:0] r32;
    if (sel == 2'd0) begin
      e.res   = {16'h0000, p[15:0], (p == 32'h0), 1'b0, 1'b0, sel};
      e.edges = 0;
    end else if (d == 16'h0) begin
      e.res   = {16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, sel};
      e.edges = 0;
    end else if (p[31:16] >= d) begin
      e.res   = {16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, sel};
      e.edges = 0;
    end else begin
      q32     = p / {16'h0, d};
      r32     = p % {16'h0, d};
      e.res   = {q32[15:0], r32[15:0], (r32 == 32'h0), 1'b0, 1'b0, sel};
      e.edges = 16;
    end
    return e;
  endfunction

  function automatic logic [36:0] obs();
    return {bus.out_q, bus.out_r, bus.out_exact, bus.out_dz, bus.out_ovf, bus.out_sel};
  endfunction

  // Presents a request, returns 1 time unit after the accepting edge.
  task automatic send(input logic [31:0] p, input logic [15:0] d, input logic [1:0] sel);
    int guard = 0;
    bus.in_p     = p;
    bus.in_d     = d;
    bus.in_sel   = sel;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    n_run++;
    if (guard >= 100) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sb.push_back(model(p, d, sel));
  endtask

  task automatic wait_out(output logic [36:0] o, output int edges);
    edges = 0;
    while (!bus.out_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    o = obs();
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || obs() !== 37'h0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%0b out_valid=%0b outs=%h required 1 0 0", bus.in_ready, bus.out_valid, obs());
    end
    rst = 1'b0;
    $display("[TB] reset in_ready=%0b out_valid=%0b", bus.in_ready, bus.out_valid);
  endtask

  task automatic test_divide();
    logic [31:0] tp [3] = '{32'h00000C00, 32'hFFFE0001, 32'd1000};
    logic [15:0] td [3] = '{16'h0030, 16'hFFFF, 16'd7};
    logic [1:0]  ts [3] = '{2'd1, 2'd3, 2'd3};
    logic [36:0] o;
    int          edges;
    exp_t        e;
    for (int i = 0; i < 3; i++) begin
      send(tp[i], td[i], ts[i]);
      wait_out(o, edges);
      e = sb.pop_front();
      n_run++;
      if (o !== e.res) begin
        n_fail++;
        $display("FAIL divide_result[%0d]: got %h required %h", i, o, e.res);
      end
      n_run++;
      if (edges !== e.edges) begin
        n_fail++;
        $display("FAIL divide_latency[%0d]: got %0d edges required %0d", i, edges, e.edges);
      end
      $display("[TB] divide p=%h d=%h q=%h r=%h exact=%0b edges=%0d", tp[i], td[i], bus.out_q, bus.out_r, bus.out_exact, edges);
      handshake();
    end
  endtask

  task automatic test_shortcuts();
    logic [31:0] tp [4] = '{32'h00001234, 32'h00050000, 32'h00000000, 32'h00000009};
    logic [15:0] td [4] = '{16'h0000, 16'h0005, 16'h0003, 16'h0003};
    logic [1:0]  ts [4] = '{2'd2, 2'd2, 2'd0, 2'd0};
    logic [36:0] o;
    int          edges;
    exp_t        e;
    for (int i = 0; i < 4; i++) begin
      send(tp[i], td[i], ts[i]);
      wait_out(o, edges);
      e = sb.pop_front();
      n_run++;
      if (o !== e.res) begin
        n_fail++;
        $display("FAIL shortcut_result[%0d]: got %h required %h", i, o, e.res);
      end
      n_run++;
      if (edges !== e.edges) begin
        n_fail++;
        $display("FAIL shortcut_latency[%0d]: got %0d edges required %0d", i, edges, e.edges);
      end
      $display("[TB] shortcut sel=%0d p=%h d=%h q=%h r=%h exact=%0b dz=%0b ovf=%0b", ts[i], tp[i], td[i], bus.out_q, bus.out_r, bus.out_exact, bus.out_dz, bus.out_ovf);
      handshake();
    end
  endtask

  task automatic test_random();
    logic [15:0] d, hi, lo;
    logic [1:0]  sel;
    logic [36:0] o;
    int          edges;
    exp_t        e;
    for (int i = 0; i < 12; i++) begin
      d   = 16'($urandom_range(1, 65535));
      hi  = 16'($urandom_range(0, int'(d) - 1));
      lo  = 16'($urandom);
      sel = (i % 4 == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      if (i == 5) hi = d;
      send({hi, lo}, d, sel);
      wait_out(o, edges);
      e = sb.pop_front();
      n_run++;
      if (o !== e.res || edges !== e.edges) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h/%0d required %h/%0d", i, o, edges, e.res, e.edges);
      end
      $display("[TB] random p=%h d=%h sel=%0d q=%h r=%h", {hi, lo}, d, sel, bus.out_q, bus.out_r);
      handshake();
    end
  endtask

  task automatic test_backpressure();
    logic [36:0] o;
    int          edges;
    exp_t        e;
    send(32'h00000C00, 16'h0030, 2'd1);
    wait_out(o, edges);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_run++;
      if (obs() !== e.res || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: outs=%h valid=%0b ready=%0b required %h 1 0", i, obs(), bus.out_valid, bus.in_ready, e.res);
      end
    end
    handshake();
    n_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL release: in_ready=%0b out_valid=%0b required 1 0", bus.in_ready, bus.out_valid);
    end
    $display("[TB] backpressure q=%h released in_ready=%0b", e.res[36:21], bus.in_ready);
  endtask

  task automatic test_back_to_back();
    logic [36:0] o;
    int          edges;
    exp_t        e;
    send(32'd1000, 16'd7, 2'd1);
    bus.in_valid = 1'b1;
    bus.in_p     = 32'h00000009;
    bus.in_d     = 16'h0001;
    bus.in_sel   = 2'd0;
    sb.push_back(model(32'h00000009, 16'h0001, 2'd0));
    wait_out(o, edges);
    e = sb.pop_front();
    n_run++;
    if (o !== e.res || edges !== e.edges) begin
      n_fail++;
      $display("FAIL b2b_first: got %h/%0d required %h/%0d", o, edges, e.res, e.edges);
    end
    $display("[TB] b2b first q=%h r=%h", bus.out_q, bus.out_r);
    handshake();
    n_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ready: in_ready=%0b out_valid=%0b required 1 0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out(o, edges);
    e = sb.pop_front();
    n_run++;
    if (o !== e.res || edges !== e.edges) begin
      n_fail++;
      $display("FAIL b2b_second: got %h/%0d required %h/%0d", o, edges, e.res, e.edges);
    end
    $display("[TB] b2b second q=%h r=%h exact=%0b", bus.out_q, bus.out_r, bus.out_exact);
    handshake();
  endtask

  task automatic test_rst_mid_run();
    logic [36:0] o;
    int          edges;
    exp_t        e;
    send(32'd1000, 16'd7, 2'd1);
    void'(sb.pop_back());
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || obs() !== 37'h0) begin
      n_fail++;
      $display("FAIL rst_mid_run: valid=%0b ready=%0b outs=%h required 0 1 0", bus.out_valid, bus.in_ready, obs());
    end
    send(32'h00000C00, 16'h0030, 2'd1);
    wait_out(o, edges);
    e = sb.pop_front();
    n_run++;
    if (o !== e.res || edges !== e.edges) begin
      n_fail++;
      $display("FAIL after_rst: got %h/%0d required %h/%0d", o, edges, e.res, e.edges);
    end
    $display("[TB] after mid-run reset q=%h r=%h edges=%0d", bus.out_q, bus.out_r, edges);
    handshake();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_p      = '0;
    bus.in_d      = '0;
    bus.in_sel    = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    test_reset();
    test_divide();
    test_shortcuts();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_rst_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
